// File: rtl/seg_mult_scheduler.sv
// Round-robin scheduler sharing one nibble converter among four requesters, driving a 4-digit muxed 7-seg display.
// Latency: ack pulses 2 cycles after req is seen in IDLE; no backpressure, losing requesters hold req until their ack.
module seg_mult_scheduler #(
    parameter int unsigned SCAN_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic [3:0] num0,
    input  logic [3:0] num1,
    input  logic [3:0] num2,
    input  logic [3:0] num3,
    output logic [3:0] ack,
    output logic       busy,
    output logic [3:0] an,
    output logic [6:0] seg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        ACK  = 2'd2
    } state_t;

    localparam logic [15:0] SCAN_LAST = 16'(SCAN_DIV - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_g;
    logic [1:0]  r_rr;
    logic [3:0]  r_ack;
    logic [3:0]  r_digit [4];
    logic [15:0] r_scan_cnt;
    logic [1:0]  r_s;

    logic        w_latch_g;
    logic        w_write;
    logic        w_release;
    logic [3:0]  w_num [4];
    logic [3:0]  w_rot;
    logic [1:0]  w_off;
    logic [1:0]  w_grant;
    logic [3:0]  w_num_sel;
    logic [3:0]  w_conv;
    logic [3:0]  w_disp;

    assign w_num[0] = num0;
    assign w_num[1] = num1;
    assign w_num[2] = num2;
    assign w_num[3] = num3;

    // Rotate requests so bit 0 is the requester at the round-robin pointer.
    always_comb begin
        w_rot = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            w_rot[i] = req[r_rr + 2'(i)];
        end
    end

    always_comb begin
        w_off = 2'd0;
        if (w_rot[0])      w_off = 2'd0;
        else if (w_rot[1]) w_off = 2'd1;
        else if (w_rot[2]) w_off = 2'd2;
        else if (w_rot[3]) w_off = 2'd3;
    end

    assign w_grant   = r_rr + w_off;
    assign w_num_sel = w_num[r_g];

    always_comb begin
        w_conv = 4'd0;
        case (w_num_sel)
            4'd0:    w_conv = 4'd0;
            4'd1:    w_conv = 4'd1;
            4'd2:    w_conv = 4'd2;
            4'd3:    w_conv = 4'd8;
            4'd4:    w_conv = 4'd10;
            4'd5:    w_conv = 4'd12;
            4'd6:    w_conv = 4'd10;
            4'd7:    w_conv = 4'd12;
            default: w_conv = 4'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_latch_g   = 1'b0;
        w_write     = 1'b0;
        w_release   = 1'b0;
        case (r_state)
            IDLE: begin
                if (req != 4'b0000) begin
                    w_latch_g   = 1'b1;
                    w_state_nxt = CALC;
                end
            end
            CALC: begin
                w_write     = 1'b1;
                w_state_nxt = ACK;
            end
            ACK: begin
                w_release   = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // The write completes even if req[g] dropped during CALC.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_g   <= 2'd0;
            r_rr  <= 2'd0;
            r_ack <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                r_digit[i] <= 4'd0;
            end
        end else begin
            if (w_latch_g) begin
                r_g <= w_grant;
            end
            if (w_write) begin
                r_digit[r_g] <= w_conv;
                r_ack        <= 4'b0001 << r_g;
            end
            if (w_release) begin
                r_ack <= 4'b0000;
                r_rr  <= r_g + 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_scan_cnt <= 16'd0;
            r_s        <= 2'd0;
        end else if (r_scan_cnt == SCAN_LAST) begin
            r_scan_cnt <= 16'd0;
            r_s        <= r_s + 2'd1;
        end else begin
            r_scan_cnt <= r_scan_cnt + 16'd1;
        end
    end

    assign ack    = r_ack;
    assign busy   = (r_state != IDLE);
    assign an     = ~(4'b0001 << r_s);
    assign w_disp = r_digit[r_s];

    always_comb begin
        seg = 7'b1111111;
        case (w_disp)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'b0001110;
            default: seg = 7'b1111111;
        endcase
    end

endmodule

// File: tb/tb_seg_mult_scheduler.sv
// Randomized plus directed bench for seg_mult_scheduler against a transaction-timestamp reference model.
module tb_seg_mult_scheduler;

    localparam int SCAN_DIV = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] num [4];
    logic [3:0] ack;
    logic       busy;
    logic [3:0] an;
    logic [6:0] seg;

    always #5 clk = ~clk;

    seg_mult_scheduler #(.SCAN_DIV(SCAN_DIV)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .req  (req),
        .num0 (num[0]),
        .num1 (num[1]),
        .num2 (num[2]),
        .num3 (num[3]),
        .ack  (ack),
        .busy (busy),
        .an   (an),
        .seg  (seg)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [6:0] hex_tab   [16];
    logic [3:0] sweep_exp [16];

    // Reference model: grant time stamps instead of a state machine.
    bit         m_valid = 1'b0;
    int         m_free_at;
    int         m_ack_cyc;
    int         m_g;
    int         m_rr;
    int         m_scan;
    logic [3:0] m_digit [4];

    int ack_log [$];
    int ack_cyc_log [$];
    int last_ack_cyc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    function automatic logic [3:0] f_ref(input int n);
        if (n <= 2)      return 4'(n);
        else if (n <= 5) return 4'((n + 1) * 2);
        else if (n <= 7) return 4'((n - 1) * 2);
        else             return 4'd0;
    endfunction

    task automatic cycle();
        int s;
        logic [3:0] e_an;
        logic [3:0] e_ack;
        @(negedge clk);
        if (m_valid) begin
            s     = (m_scan / SCAN_DIV) % 4;
            e_an  = ~(4'b0001 << s);
            e_ack = (cyc == m_ack_cyc) ? 4'(1 << m_g) : 4'b0000;
            chk("busy", 32'(busy), 32'(cyc < m_free_at));
            chk("ack", 32'(ack), 32'(e_ack));
            chk("an", 32'(an), 32'(e_an));
            chk("seg", 32'(seg), 32'(hex_tab[m_digit[s]]));
            if (ack != 4'b0000) begin
                for (int i = 0; i < 4; i++) begin
                    if (ack[i]) ack_log.push_back(i);
                end
                ack_cyc_log.push_back(cyc);
                last_ack_cyc = cyc;
            end
            req = req & ~ack;
        end
        @(posedge clk);
        if (!rst_n) begin
            m_valid   = 1'b1;
            m_free_at = cyc + 1;
            m_ack_cyc = -10;
            m_g       = 0;
            m_rr      = 0;
            m_scan    = 0;
            for (int i = 0; i < 4; i++) m_digit[i] = 4'd0;
        end else if (m_valid) begin
            m_scan = (m_scan + 1) % (4 * SCAN_DIV);
            if (cyc == m_ack_cyc - 1) m_digit[m_g] = f_ref(int'(num[m_g]));
            if (cyc == m_ack_cyc) m_rr = (m_g + 1) % 4;
            if (cyc >= m_free_at && req != 4'b0000) begin
                for (int k = 3; k >= 0; k--) begin
                    if (req[(m_rr + k) % 4]) m_g = (m_rr + k) % 4;
                end
                m_ack_cyc = cyc + 2;
                m_free_at = cyc + 3;
            end
        end
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 4'b0000;
        cycle();
        rst_n = 1'b1;
    endtask

    task automatic wait_digit(input int d, input logic [6:0] exp_seg, input string tag);
        logic [3:0] want_an;
        bit seen;
        want_an = ~(4'b0001 << d);
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            if (an == want_an) begin
                chk(tag, 32'(seg), 32'(exp_seg));
                seen = 1'b1;
            end else begin
                cycle();
            end
        end
        if (!seen) chk({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        int t;
        logic [3:0] e_an;
        hex_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        sweep_exp = '{4'h0, 4'h1, 4'h2, 4'h8, 4'hA, 4'hC, 4'hA, 4'hC,
                      4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        rst_n = 1'b0;
        req   = 4'b0000;
        for (int i = 0; i < 4; i++) num[i] = 4'd0;
        last_ack_cyc = -100;
        repeat (3) cycle();
        rst_n = 1'b1;

        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_an", 32'(an), 32'(4'b1110));
        chk("rst_seg", 32'(seg), 32'(7'b1000000));

        // Scan sweep straight out of reset.
        for (int k = 0; k < 40; k++) begin
            e_an = ~(4'b0001 << ((k / SCAN_DIV) % 4));
            chk("scan_an", 32'(an), 32'(e_an));
            cycle();
        end

        // Single request.
        ack_log.delete();
        num[0] = 4'd3;
        req    = 4'b0001;
        t      = cyc;
        repeat (4) cycle();
        chk("single_lat", 32'(last_ack_cyc - t), 32'd2);
        chk("single_idx", 32'(ack_log.size() == 1 ? ack_log[0] : 99), 32'd0);
        wait_digit(0, 7'b0000000, "single_seg");

        // Full sweep on requester 1.
        for (int n = 0; n < 16; n++) begin
            num[1] = 4'(n);
            req    = 4'b0010;
            repeat (4) cycle();
            wait_digit(1, hex_tab[sweep_exp[n]], "sweep_seg");
        end

        // Contention: all four at once right after reset.
        do_reset();
        for (int i = 0; i < 4; i++) num[i] = 4'($urandom_range(0, 15));
        ack_log.delete();
        ack_cyc_log.delete();
        req = 4'b1111;
        repeat (14) cycle();
        chk("cont_cnt", 32'(ack_log.size()), 32'd4);
        for (int i = 0; i < 4 && i < ack_log.size(); i++) chk("cont_order", 32'(ack_log[i]), 32'(i));
        for (int i = 1; i < ack_cyc_log.size(); i++)
            chk("cont_gap", 32'(ack_cyc_log[i] - ack_cyc_log[i-1]), 32'd3);

        // Fairness: serve requester 1 so the pointer sits at 2.
        do_reset();
        num[1] = 4'($urandom_range(0, 15));
        req    = 4'b0010;
        repeat (4) cycle();
        ack_log.delete();
        num[0] = 4'd4;
        num[2] = 4'd6;
        req    = 4'b0101;
        repeat (8) cycle();
        chk("fair_cnt", 32'(ack_log.size()), 32'd2);
        if (ack_log.size() == 2) begin
            chk("fair_first", 32'(ack_log[0]), 32'd2);
            chk("fair_second", 32'(ack_log[1]), 32'd0);
        end

        // Reset while in CALC aborts the conversion.
        do_reset();
        num[0] = 4'd5;
        req    = 4'b0001;
        cycle();
        rst_n = 1'b0;
        req   = 4'b0000;
        cycle();
        rst_n = 1'b1;
        chk("rcalc_an", 32'(an), 32'(4'b1110));
        chk("rcalc_ack_now", 32'(ack), 32'd0);
        ack_log.delete();
        repeat (20) cycle();
        chk("rcalc_acks", 32'(ack_log.size()), 32'd0);
        wait_digit(0, 7'b1000000, "rcalc_seg");

        // Requester drops req during CALC; ack still arrives.
        num[3] = 4'd7;
        req    = 4'b1000;
        t      = cyc;
        cycle();
        req = 4'b0000;
        repeat (4) cycle();
        chk("drop_lat", 32'(last_ack_cyc - t), 32'd2);
        wait_digit(3, 7'b1000110, "drop_seg");

        // Random traffic with occasional resets and early drops.
        for (int k = 0; k < 800; k++) begin
            for (int i = 0; i < 4; i++) begin
                if (!req[i] && $urandom_range(0, 3) == 0) begin
                    num[i] = 4'($urandom_range(0, 15));
                    req[i] = 1'b1;
                end else if (req[i] && $urandom_range(0, 24) == 0) begin
                    req[i] = 1'b0;
                end
            end
            rst_n = ($urandom_range(0, 59) != 0);
            cycle();
            rst_n = 1'b1;
        end

        req = 4'b0000;
        repeat (4) cycle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
